rational_eval_seq: RTL and testbench

Sequential evaluator for the rational function N(z)/D(z) = Π(z − zero_k) / Π(z − pole_k) at complex sample z = x + jy. It owns the root register file and time-shares one complex multiplier across all factors, one factor per clock. It sits between the pixel/coordinate generator (valid/ready upstream) and the colour-mapping stage (valid/ready downstream), and accepts root configuration from the control interface.

---
 rtl/func_eval_pkg.sv | 43 ++++
 rtl/rational_eval_seq_cmul_q.sv | 32 +++
 rtl/rational_eval_seq.sv | 146 ++++++++++++++
 tb/tb_rational_eval_seq.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/func_eval_pkg.sv
// Shared types and arithmetic helpers for the rational-function evaluator.
package func_eval_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  // Wide enough for a full complex-multiply sum of two products.
  localparam int WIDE_W     = 2 * DATA_WIDTH + 1;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } cplx_t;

  // 1.0 + 0j in the Q format.
  localparam cplx_t ONE = {DATA_WIDTH'(1 << FRAC_BITS), DATA_WIDTH'(0)};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NUM  = 2'd1,
    S_DEN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic signed [WIDE_W-1:0] SAT_MAX =
    {{(WIDE_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAT_MIN =
    {{(WIDE_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Sign-extend a data word to the wide arithmetic width.
  function automatic logic signed [WIDE_W-1:0] sext_dw(input logic [DATA_WIDTH-1:0] v);
    return {{(WIDE_W-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  // Clamp a wide signed value into the signed data range (no wrap).
  function automatic logic [DATA_WIDTH-1:0] sat_dw(input logic signed [WIDE_W-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[DATA_WIDTH-1:0];
    else                  r = v[DATA_WIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/rational_eval_seq_cmul_q.sv
// Combinational Q-format complex multiply: full-precision products,
// arithmetic shift by FRAC_BITS (floor), then saturation per component.
module cmul_q
  import func_eval_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_a_re,
  input  logic [DATA_WIDTH-1:0] i_a_im,
  input  logic [DATA_WIDTH-1:0] i_b_re,
  input  logic [DATA_WIDTH-1:0] i_b_im,
  output logic [DATA_WIDTH-1:0] o_p_re,
  output logic [DATA_WIDTH-1:0] o_p_im
);

  logic signed [WIDE_W-1:0] w_ar, w_ai, w_br, w_bi;
  logic signed [WIDE_W-1:0] w_re, w_im, w_re_sh, w_im_sh;

  assign w_ar = sext_dw(i_a_re);
  assign w_ai = sext_dw(i_a_im);
  assign w_br = sext_dw(i_b_re);
  assign w_bi = sext_dw(i_b_im);

  // Each product fits in 2*DATA_WIDTH bits, so the wide truncation is exact.
  assign w_re = (w_ar * w_br) - (w_ai * w_bi);
  assign w_im = (w_ar * w_bi) + (w_ai * w_br);

  assign w_re_sh = w_re >>> FRAC_BITS;
  assign w_im_sh = w_im >>> FRAC_BITS;

  assign o_p_re = sat_dw(w_re_sh);
  assign o_p_im = sat_dw(w_im_sh);

endmodule

// File: rtl/rational_eval_seq.sv
// Sequential N(z)/D(z) evaluator: one shared complex multiplier, one factor
// per clock (zeros first, then poles), result held in DONE until taken.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid, and valid holds until transfer.
module rational_eval_seq
  import func_eval_pkg::*;
#(
  parameter int ZERO_COUNT = 4,
  parameter int POLE_COUNT = 4,
  parameter int IDX_W = ((ZERO_COUNT > POLE_COUNT ? ZERO_COUNT : POLE_COUNT) > 1) ?
                        $clog2(ZERO_COUNT > POLE_COUNT ? ZERO_COUNT : POLE_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic                  cfg_sel,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [DATA_WIDTH-1:0] cfg_re,
  input  logic [DATA_WIDTH-1:0] cfg_im,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] y_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] numerator_re,
  output logic [DATA_WIDTH-1:0] numerator_im,
  output logic [DATA_WIDTH-1:0] denominator_re,
  output logic [DATA_WIDTH-1:0] denominator_im,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int IW1 = IDX_W + 1;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  cplx_t            r_z, r_num, r_den, r_out_num, r_out_den;
  cplx_t            r_zero [ZERO_COUNT];
  cplx_t            r_pole [POLE_COUNT];
  logic             r_cfg_err;

  logic             w_accept, w_last_zero, w_last_pole, w_in_range, w_wr_ok;
  cplx_t            w_root, w_acc, w_diff;
  logic [DATA_WIDTH-1:0] w_prod_re, w_prod_im;

  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_last_zero = (r_idx == IDX_W'(ZERO_COUNT - 1));
  assign w_last_pole = (r_idx == IDX_W'(POLE_COUNT - 1));
  assign w_in_range  = cfg_sel ? ({1'b0, cfg_idx} < IW1'(POLE_COUNT))
                               : ({1'b0, cfg_idx} < IW1'(ZERO_COUNT));
  assign w_wr_ok     = cfg_we && (r_state == S_IDLE) && w_in_range;

  // Shared multiplier operands: the accumulator and root of the active bank.
  assign w_acc   = (r_state == S_DEN) ? r_den : r_num;
  assign w_root  = (r_state == S_DEN) ? r_pole[r_idx] : r_zero[r_idx];
  assign w_diff.re = sat_dw(sext_dw(r_z.re) - sext_dw(w_root.re));
  assign w_diff.im = sat_dw(sext_dw(r_z.im) - sext_dw(w_root.im));

  cmul_q u_cmul (
    .i_a_re (w_acc.re),
    .i_a_im (w_acc.im),
    .i_b_re (w_diff.re),
    .i_b_im (w_diff.im),
    .o_p_re (w_prod_re),
    .o_p_im (w_prod_im)
  );

  // Root banks: written only while idle, so an evaluation sees a frozen set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ZERO_COUNT; k++) r_zero[k] <= '0;
      for (int k = 0; k < POLE_COUNT; k++) r_pole[k] <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && !w_wr_ok;
      if (w_wr_ok && !cfg_sel) r_zero[cfg_idx] <= {cfg_re, cfg_im};
      if (w_wr_ok &&  cfg_sel) r_pole[cfg_idx] <= {cfg_re, cfg_im};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: one factor per cycle, hold in DONE until taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)    w_state_nxt = S_NUM;
      S_NUM:   if (w_last_zero) w_state_nxt = S_DEN;
      S_DEN:   if (w_last_pole) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)   w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch z, accumulate products, capture results on the last pole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z       <= '0;
      r_num     <= '0;
      r_den     <= '0;
      r_out_num <= '0;
      r_out_den <= '0;
      r_idx     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_z.re <= x_in;
          r_z.im <= y_in;
          r_num  <= ONE;
          r_den  <= ONE;
          r_idx  <= '0;
        end
        S_NUM: begin
          r_num <= {w_prod_re, w_prod_im};
          r_idx <= w_last_zero ? '0 : r_idx + IDX_W'(1);
        end
        S_DEN: begin
          r_den <= {w_prod_re, w_prod_im};
          r_idx <= w_last_pole ? '0 : r_idx + IDX_W'(1);
          if (w_last_pole) begin
            r_out_num <= r_num;
            r_out_den <= {w_prod_re, w_prod_im};
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready       = (r_state == S_IDLE);
  assign out_valid      = (r_state == S_DONE);
  assign busy           = (r_state != S_IDLE);
  assign cfg_err        = r_cfg_err;
  assign dbg_state      = r_state;
  assign numerator_re   = r_out_num.re;
  assign numerator_im   = r_out_num.im;
  assign denominator_re = r_out_den.re;
  assign denominator_im = r_out_den.im;

endmodule

// File: tb/tb_rational_eval_seq.sv
// Bench for rational_eval_seq: scenario tasks, model-driven expected queue.
`timescale 1ns/1ps
module tb_rational_eval_seq;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [15:0] cfg_re = '0, cfg_im = '0;
  logic        cfg_err;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] x_in = '0, y_in = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] numerator_re, numerator_im, denominator_re, denominator_im;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  rational_eval_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
    .cfg_re(cfg_re), .cfg_im(cfg_im), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .numerator_re(numerator_re), .numerator_im(numerator_im),
    .denominator_re(denominator_re), .denominator_im(denominator_im),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state / model ----------------
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  longint      m_zr[4], m_zi[4], m_pr[4], m_pi[4];
  time         t_acc;

  function automatic longint sat16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: product of factors with floor-shifted, clamped Q8 arithmetic.
  function automatic logic [63:0] model(longint x, longint y);
    longint nr, ni, dr, di, br, bi, tr, ti;
    nr = 256; ni = 0; dr = 256; di = 0;
    for (int k = 0; k < 4; k++) begin
      br = sat16(x - m_zr[k]); bi = sat16(y - m_zi[k]);
      tr = sat16((nr * br - ni * bi) >>> 8);
      ti = sat16((nr * bi + ni * br) >>> 8);
      nr = tr; ni = ti;
    end
    for (int k = 0; k < 4; k++) begin
      br = sat16(x - m_pr[k]); bi = sat16(y - m_pi[k]);
      tr = sat16((dr * br - di * bi) >>> 8);
      ti = sat16((dr * bi + di * br) >>> 8);
      dr = tr; di = ti;
    end
    return {nr[15:0], ni[15:0], dr[15:0], di[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_root(input logic sel, input logic [1:0] idx,
                            input logic [15:0] re, input logic [15:0] im);
    cfg_we = 1'b1; cfg_sel = sel; cfg_idx = idx; cfg_re = re; cfg_im = im;
    tick();
    cfg_we = 1'b0;
    if (sel) begin m_pr[idx] = longint'($signed(re)); m_pi[idx] = longint'($signed(im)); end
    else     begin m_zr[idx] = longint'($signed(re)); m_zi[idx] = longint'($signed(im)); end
  endtask

  task automatic clear_roots();
    for (int k = 0; k < 4; k++) begin
      write_root(1'b0, 2'(k), 16'h0000, 16'h0000);
      write_root(1'b1, 2'(k), 16'h0000, 16'h0000);
    end
  endtask

  // Offer a sample until accepted; optionally write a root on the acceptance edge.
  task automatic drive_sample(input logic [15:0] x, input logic [15:0] y,
                              input bit do_wr, input logic sel, input logic [1:0] idx,
                              input logic [15:0] re, input logic [15:0] im);
    int n = 0;
    in_valid = 1'b1; x_in = x; y_in = y;
    while (!in_ready && n < 40) begin tick(); n++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
    end
    if (do_wr) begin
      cfg_we = 1'b1; cfg_sel = sel; cfg_idx = idx; cfg_re = re; cfg_im = im;
      if (sel) begin m_pr[idx] = longint'($signed(re)); m_pi[idx] = longint'($signed(im)); end
      else     begin m_zr[idx] = longint'($signed(re)); m_zi[idx] = longint'($signed(im)); end
    end
    exp_q.push_back(model(longint'($signed(x)), longint'($signed(y))));
    @(posedge clk);
    t_acc = $time;
    #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    x_in = 16'($urandom); y_in = 16'($urandom);
  endtask

  // Wait (bounded) for out_valid; report edges since acceptance.
  task automatic wait_result(output int lat);
    int n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    lat = int'(($time - t_acc - 1) / 10);
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy, cfg_err, in_ready, dbg_state} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_ctrl got v/b/e/r/st=%b required=000100",
               {out_valid, busy, cfg_err, in_ready, dbg_state});
    end
    checks++;
    if ({numerator_re, numerator_im, denominator_re, denominator_im} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got %h required 0",
               {numerator_re, numerator_im, denominator_re, denominator_im});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    tick();
  endtask

  task automatic run_const_case(input string name, input logic [15:0] x, input logic [15:0] y,
                                input logic [63:0] want);
    int lat; logic [63:0] exp, got;
    drive_sample(x, y, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL %s_busy got busy=%b in_ready=%b required 1/0", name, busy, in_ready);
    end
    wait_result(lat);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL %s_latency got %0d required 8", name, lat); end
    exp = exp_q.pop_front();
    got = {numerator_re, numerator_im, denominator_re, denominator_im};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL %s_model got %h required %h", name, got, exp); end
    checks++;
    if (got !== want) begin errors++; $display("FAIL %s_const got %h required %h", name, got, want); end
    tick();
  endtask

  task automatic test_all_zero_one();
    run_const_case("zero_roots", 16'h0100, 16'h0000, 64'h0100_0000_0100_0000);
  endtask

  task automatic test_mixed_roots();
    write_root(1'b0, 2'd0, 16'h0100, 16'h0000);
    for (int k = 0; k < 4; k++) write_root(1'b1, 2'(k), 16'h0080, 16'h0000);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL idle_write_err got %b required 0", cfg_err); end
    run_const_case("mixed", 16'h0200, 16'h0000, 64'h0800_0000_0510_0000);
  endtask

  task automatic test_imag();
    clear_roots();
    run_const_case("imag", 16'h0000, 16'h0100, 64'h0100_0000_0100_0000);
  endtask

  task automatic test_saturation();
    run_const_case("sat", 16'h6400, 16'h0000, 64'h7FFF_0000_7FFF_0000);
  endtask

  task automatic test_backpressure();
    int lat; bit ok; logic [63:0] exp, got;
    write_root(1'b1, 2'd1, 16'h0020, 16'hFFF0);
    write_root(1'b0, 2'd3, 16'hFF80, 16'h0040);
    out_ready = 1'b0;
    drive_sample(16'h0140, 16'h0030, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
    // Attempt to overwrite pole 1 mid-evaluation; model is left untouched.
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_idx = 2'd1; cfg_re = 16'h0100; cfg_im = 16'h0000;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL busy_write_err got %b required 1", cfg_err); end
    tick();
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_pulse_len got %b required 0", cfg_err); end
    wait_result(lat);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL bp_latency got %0d required 8", lat); end
    exp = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      got = {numerator_re, numerator_im, denominator_re, denominator_im};
      ok = (out_valid === 1'b1) && (in_ready === 1'b0) && (got === exp);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b r=%b data=%h required v=1 r=0 data=%h",
                 c, out_valid, in_ready, got, exp);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got v=%b r=%b required 0/1", out_valid, in_ready);
    end
    drive_sample(16'hFF00, 16'h0090, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
    wait_result(lat);
    exp = exp_q.pop_front();
    got = {numerator_re, numerator_im, denominator_re, denominator_im};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL bp_root_kept got %h required %h", got, exp); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat; bit seen; logic [63:0] exp, got;
    write_root(1'b0, 2'd1, 16'h0040, 16'h0000);
    drive_sample(16'h0180, 16'h0040, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
    repeat (2) tick();
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    for (int k = 0; k < 4; k++) begin m_zr[k] = 0; m_zi[k] = 0; m_pr[k] = 0; m_pi[k] = 0; end
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%b busy=%b st=%0d required 0/0/0", out_valid, busy, dbg_state);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin if (out_valid) seen = 1'b1; tick(); end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_reset_no_out got out_valid=1 required 0"); end
    drive_sample(16'h0180, 16'h0040, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
    wait_result(lat);
    exp = exp_q.pop_front();
    got = {numerator_re, numerator_im, denominator_re, denominator_im};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_reset_roots got %h required %h", got, exp); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat; time prev; logic [63:0] exp, got;
    for (int k = 0; k < 4; k++) begin
      write_root(1'b0, 2'(k), 16'($urandom_range(0, 1023)) - 16'd512,
                 16'($urandom_range(0, 1023)) - 16'd512);
      write_root(1'b1, 2'(k), 16'($urandom_range(0, 1023)) - 16'd512,
                 16'($urandom_range(0, 1023)) - 16'd512);
    end
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      drive_sample(16'($urandom_range(0, 1535)) - 16'd768, 16'($urandom_range(0, 1535)) - 16'd768,
                   (i == 1), 1'b0, 2'd2, 16'h00C0, 16'hFF40);
      if (i == 1) begin
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL same_cycle_write_err got %b required 0", cfg_err); end
      end
      if (i > 0) begin
        checks++;
        if (t_acc - prev !== 100) begin
          errors++; $display("FAIL b2b_period got %0t required 100", t_acc - prev);
        end
      end
      prev = t_acc;
      wait_result(lat);
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL b2b_latency %0d got %0d required 8", i, lat); end
      exp = exp_q.pop_front();
      got = {numerator_re, numerator_im, denominator_re, denominator_im};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_data %0d got %h required %h", i, got, exp); end
    end
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int k = 0; k < 4; k++) begin m_zr[k] = 0; m_zi[k] = 0; m_pr[k] = 0; m_pi[k] = 0; end
    test_reset();
    test_all_zero_one();
    test_mixed_roots();
    test_imag();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_expected got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
